// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED, switch, 7-seg and systick registers for the MEM stage
module peripheral_bus #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led,
  output logic [11:0]      digi,
  output logic             irqout
);
  logic [31:0] th_q, th_d, tl_q, tl_d, systick_q;
  logic [2:0] tcon_q, tcon_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [SW_W-1:0] sw_meta_q, sw_q;
  logic sel_th, sel_tl, sel_tcon, sel_led, sel_sw, sel_digi, sel_tick, ovf;
  assign sel_th   = addr == BASE_ADDR;
  assign sel_tl   = addr == BASE_ADDR + 32'h04;
  assign sel_tcon = addr == BASE_ADDR + 32'h08;
  assign sel_led  = addr == BASE_ADDR + 32'h0C;
  assign sel_sw   = addr == BASE_ADDR + 32'h10;
  assign sel_digi = addr == BASE_ADDR + 32'h14;
  assign sel_tick = addr == BASE_ADDR + 32'h18;
  assign ovf      = tl_q == 32'hFFFF_FFFF;
  // CPU writes take priority over timer increment, reload and status set
  always_comb begin
    th_d   = wr && sel_th ? wdata : th_q;
    tl_d   = wr && sel_tl ? wdata : !tcon_q[0] ? tl_q : ovf ? th_q : tl_q + 32'd1;
    tcon_d = wr && sel_tcon ? wdata[2:0]
           : {tcon_q[2] | (tcon_q[0] & tcon_q[1] & ovf), tcon_q[1:0]};
    led_d  = wr && sel_led ? wdata[LED_W-1:0] : led_q;
    digi_d = wr && sel_digi ? wdata[11:0] : digi_q;
    rdata  = !rd      ? 32'd0
           : sel_th   ? th_q
           : sel_tl   ? tl_q
           : sel_tcon ? 32'(tcon_q)
           : sel_led  ? 32'(led_q)
           : sel_sw   ? 32'(sw_q)
           : sel_digi ? 32'(digi_q)
           : sel_tick ? systick_q
           : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      sw_meta_q <= '0;
      sw_q      <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_q + 32'd1;
      sw_meta_q <= switch;
      sw_q      <= sw_meta_q;
    end
  end
  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[2];
endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: directed vectors plus timer/switch sequences for peripheral_bus
module tb_peripheral_bus;
  localparam logic [31:0] B = 32'h4000_0000;
  localparam logic [31:0] A_TH = B, A_TL = B + 32'h04, A_TCON = B + 32'h08, A_LED = B + 32'h0C;
  localparam logic [31:0] A_SW = B + 32'h10, A_DIGI = B + 32'h14, A_TICK = B + 32'h18;
  logic clk = 0, reset, rd, wr, irqout;
  logic [31:0] addr, wdata, rdata;
  logic [7:0] switch, led;
  logic [11:0] digi;
  int checks = 0, errors = 0;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
  } vec_t;
  vec_t vecs[$];
  peripheral_bus dut (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata), .switch(switch), .led(led), .digi(digi), .irqout(irqout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input string nm);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1 chk(nm, rdata, er);
  endtask
  initial begin
    vecs.push_back('{1, 0, A_TH,        32'h0,         32'h0,   8'h00});
    vecs.push_back('{1, 0, A_TL,        32'h0,         32'h0,   8'h00});
    vecs.push_back('{1, 0, A_TCON,      32'h0,         32'h0,   8'h00});
    vecs.push_back('{1, 0, A_LED,       32'h0,         32'h0,   8'h00});
    vecs.push_back('{1, 0, A_DIGI,      32'h0,         32'h0,   8'h00});
    vecs.push_back('{0, 1, A_LED,       32'hFFFF_FF55, 32'h0,   8'h00});
    vecs.push_back('{1, 0, A_LED,       32'h0,         32'h55,  8'h55});
    vecs.push_back('{0, 1, B + 32'h0D,  32'hAA,        32'h0,   8'h55});
    vecs.push_back('{0, 1, A_SW,        32'hAA,        32'h0,   8'h55});
    vecs.push_back('{1, 0, A_LED,       32'h0,         32'h55,  8'h55});
    vecs.push_back('{1, 0, B + 32'h1C,  32'h0,         32'h0,   8'h55});
    vecs.push_back('{0, 1, A_DIGI,      32'hFFFF_FABC, 32'h0,   8'h55});
    vecs.push_back('{1, 0, A_DIGI,      32'h0,         32'hABC, 8'h55});
    vecs.push_back('{1, 1, A_LED,       32'h33,        32'h55,  8'h55});
    vecs.push_back('{1, 0, A_LED,       32'h0,         32'h33,  8'h33});
    vecs.push_back('{1, 0, B + 32'h0D,  32'h0,         32'h0,   8'h33});
    vecs.push_back('{0, 1, A_TH,        32'h1234,      32'h0,   8'h33});
    vecs.push_back('{1, 0, A_TH,        32'h0,         32'h1234,8'h33});
    vecs.push_back('{1, 0, 32'h0000_0000,32'h0,        32'h0,   8'h33});
    vecs.push_back('{1, 0, A_SW,        32'h0,         32'h0,   8'h33});
    // reset held two edges while a TH write is attempted
    reset = 1; rd = 0; wr = 1; addr = A_TH; wdata = 32'hDEAD_BEEF; switch = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0; wr = 0; rd = 1; addr = A_TICK;
    #1 chk("systick0", rdata, 32'd0);
    chk("irq_rst", {31'd0, irqout}, 32'd0);
    chk("led_rst", {24'd0, led}, 32'd0);
    chk("digi_rst", {20'd0, digi}, 32'd0);
    for (int i = 1; i <= 3; i++) step(1, 0, A_TICK, 0, i, $sformatf("systick%0d", i));
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d_rdata", i));
      chk($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
    end
    chk("digi_pin", {20'd0, digi}, 32'hABC);
    // switch synchronizer latency
    @(negedge clk); switch = 8'hA5; rd = 1; wr = 0; addr = A_SW;
    #1 chk("sw_edge0", rdata, 32'h0);
    step(1, 0, A_SW, 0, 32'h0, "sw_edge1");
    step(1, 0, A_SW, 0, 32'hA5, "sw_edge2");
    // overflow reload with interrupt
    step(0, 1, A_TH, 32'hFFFF_FFFC, 0, "wr_th");
    step(0, 1, A_TL, 32'hFFFF_FFFE, 0, "wr_tl");
    step(0, 1, A_TCON, 32'h3, 0, "wr_tcon");
    step(1, 0, A_TL, 0, 32'hFFFF_FFFE, "tl_run0");
    step(1, 0, A_TL, 0, 32'hFFFF_FFFF, "tl_run1");
    chk("irq_pre", {31'd0, irqout}, 32'd0);
    step(1, 0, A_TL, 0, 32'hFFFF_FFFC, "tl_reload");
    chk("irq_set", {31'd0, irqout}, 32'd1);
    step(1, 0, A_TL, 0, 32'hFFFF_FFFD, "tl_after");
    chk("irq_sticky", {31'd0, irqout}, 32'd1);
    step(1, 0, A_TCON, 0, 32'h7, "tcon_7");
    // TL write beats increment while running
    step(0, 1, A_TL, 32'h5, 0, "wr_tl5");
    step(1, 0, A_TL, 0, 32'h5, "tl_wr_wins");
    step(1, 0, A_TL, 0, 32'h6, "tl_inc");
    step(0, 1, A_TCON, 32'h0, 0, "stop");
    step(1, 0, A_TCON, 0, 32'h0, "tcon_clr");
    chk("irq_clr", {31'd0, irqout}, 32'd0);
    // clear race: TCON write at the overflow edge
    step(0, 1, A_TL, 32'hFFFF_FFFE, 0, "race_tl");
    step(0, 1, A_TCON, 32'h3, 0, "race_tcon");
    step(1, 0, A_TL, 0, 32'hFFFF_FFFE, "race_run0");
    step(1, 1, A_TCON, 32'h3, 32'h3, "race_wr");
    step(1, 0, A_TL, 0, 32'hFFFF_FFFC, "race_reload");
    chk("race_irq", {31'd0, irqout}, 32'd0);
    step(1, 0, A_TCON, 0, 32'h3, "race_tcon3");
    // irq disabled, plus TH write during the reload edge
    step(0, 1, A_TCON, 32'h0, 0, "dis_stop");
    step(0, 1, A_TL, 32'hFFFF_FFFE, 0, "dis_tl");
    step(0, 1, A_TCON, 32'h1, 0, "dis_tcon");
    step(1, 0, A_TL, 0, 32'hFFFF_FFFE, "dis_run0");
    step(1, 1, A_TH, 32'h100, 32'hFFFF_FFFC, "dis_th_wr");
    step(1, 0, A_TL, 0, 32'hFFFF_FFFC, "dis_reload_old_th");
    chk("dis_irq", {31'd0, irqout}, 32'd0);
    step(1, 0, A_TH, 0, 32'h100, "dis_th_new");
    step(1, 0, A_TCON, 0, 32'h1, "dis_tcon1");
    chk("dis_irq2", {31'd0, irqout}, 32'd0);
    step(0, 0, A_TH, 0, 32'h0, "idle_rdata");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
